fft_sequencer: RTL

- Control and address-generation unit for the in-place radix-2 DIT FFT core. The core is built from the complex_mult butterfly datapath, a dual-port sample RAM and a twiddle ROM.
- Runs three phases in order:
  - LOAD: writes incoming samples to the RAM at bit-reversed addresses.
  - COMPUTE: schedules every butterfly of all L stages.
  - UNLOAD: reads results out in natural order.
- The controller produces addresses and strobes only. It never touches sample data.

---
 rtl/fft_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_sequencer.sv
// Control and address generator for an in-place radix-2 DIT FFT.
// Sequences LOAD (bit-reversed writes), COMPUTE/DRAIN (butterflies per stage) and UNLOAD.
module fft_sequencer #(
  parameter int L      = 5,
  parameter int BF_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_we,
  output logic [L-1:0]      load_addr,
  output logic              bf_rd,
  output logic [L-1:0]      bf_adr_a,
  output logic [L-1:0]      bf_adr_b,
  output logic [L-2:0]      tw_addr,
  output logic              wr_en,
  output logic [L-1:0]      wr_adr_a,
  output logic [L-1:0]      wr_adr_b,
  output logic              out_valid,
  output logic [L-1:0]      out_addr,
  output logic              out_last,
  output logic [$clog2(L):0] stage,
  output logic              busy,
  output logic              done
);

  localparam int SW = $clog2(L) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD, DONE} state_e;

  typedef struct packed {
    logic         en;
    logic [L-1:0] a;
    logic [L-1:0] b;
  } wb_t;

  state_e         state_q, state_d;
  logic [L-1:0]   k_q, k_d;
  logic [L-2:0]   j_q, j_d;
  logic [SW-1:0]  s_q, s_d;
  logic [2:0]     dr_q, dr_d;
  logic [L-1:0]   u_q, u_d;

  logic           in_ready_q, in_ready_d;
  logic [L-1:0]   load_addr_q, load_addr_d;
  logic           bf_rd_q, bf_rd_d;
  logic [L-1:0]   bf_adr_a_q, bf_adr_a_d;
  logic [L-1:0]   bf_adr_b_q, bf_adr_b_d;
  logic [L-2:0]   tw_addr_q, tw_addr_d;
  logic [L-2:0]   tw_mask;
  logic           out_valid_q, out_valid_d;
  logic [L-1:0]   out_addr_q, out_addr_d;
  logic           out_last_q, out_last_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  wb_t            wb_q [BF_LAT];

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] x);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = x[L-1-i];
    return r;
  endfunction

  // Rotate left within L bits: the upper half of {x,x} << s is the rotation.
  function automatic logic [L-1:0] rotl(input logic [L-1:0] x, input logic [SW-1:0] s);
    logic [2*L-1:0] t;
    t = {x, x} << s;
    return t[2*L-1:L];
  endfunction

  assign load_we = in_valid & in_ready_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      j_q     <= '0;
      s_q     <= '0;
      dr_q    <= '0;
      u_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      s_q     <= s_d;
      dr_q    <= dr_d;
      u_q     <= u_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    s_d     = s_q;
    dr_d    = dr_q;
    u_d     = u_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        k_d     = '0;
      end
      LOAD: if (load_we) begin
        if (k_q == '1) begin
          state_d = COMPUTE;
          j_d     = '0;
          s_d     = '0;
        end else begin
          k_d = k_q + L'(1);
        end
      end
      COMPUTE: begin
        if (j_q == '1) begin
          state_d = DRAIN;
          dr_d    = '0;
        end else begin
          j_d = j_q + (L-1)'(1);
        end
      end
      DRAIN: begin
        if (dr_q == 3'(BF_LAT - 1)) begin
          if (s_q == SW'(L - 1)) begin
            state_d = UNLOAD;
            u_d     = '0;
          end else begin
            state_d = COMPUTE;
            s_d     = s_q + SW'(1);
            j_d     = '0;
          end
        end else begin
          dr_d = dr_q + 3'(1);
        end
      end
      UNLOAD: begin
        if (u_q == '1) state_d = DONE;
        else           u_d     = u_q + L'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    tw_mask     = {(L-1){1'b1}} << (SW'(L - 1) - s_d);
    in_ready_d  = (state_d == LOAD);
    load_addr_d = (state_d == LOAD) ? bitrev(k_d) : '0;
    bf_rd_d     = (state_d == COMPUTE);
    bf_adr_a_d  = bf_rd_d ? rotl({j_d, 1'b0}, s_d) : '0;
    bf_adr_b_d  = bf_rd_d ? rotl({j_d, 1'b1}, s_d) : '0;
    tw_addr_d   = bf_rd_d ? (j_d & tw_mask) : '0;
    stage_d     = (state_d == COMPUTE || state_d == DRAIN) ? s_d : '0;
    out_valid_d = (state_d == UNLOAD);
    out_addr_d  = out_valid_d ? u_d : '0;
    out_last_d  = out_valid_d && (u_d == '1);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      load_addr_q <= '0;
      bf_rd_q     <= 1'b0;
      bf_adr_a_q  <= '0;
      bf_adr_b_q  <= '0;
      tw_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      stage_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      load_addr_q <= load_addr_d;
      bf_rd_q     <= bf_rd_d;
      bf_adr_a_q  <= bf_adr_a_d;
      bf_adr_b_q  <= bf_adr_b_d;
      tw_addr_q   <= tw_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      stage_q     <= stage_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the write-back delay line is reset so no stale butterfly writes escape after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BF_LAT; i++) wb_q[i] <= '0;
    end else begin
      wb_q[0] <= {bf_rd_q, bf_adr_a_q, bf_adr_b_q};
      for (int i = 1; i < BF_LAT; i++) wb_q[i] <= wb_q[i-1];
    end
  end

  assign in_ready  = in_ready_q;
  assign load_addr = load_addr_q;
  assign bf_rd     = bf_rd_q;
  assign bf_adr_a  = bf_adr_a_q;
  assign bf_adr_b  = bf_adr_b_q;
  assign tw_addr   = tw_addr_q;
  assign wr_en     = wb_q[BF_LAT-1].en;
  assign wr_adr_a  = wb_q[BF_LAT-1].a;
  assign wr_adr_b  = wb_q[BF_LAT-1].b;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
